// File: rtl/gauss_pkg.sv
// Shared constants, kernel weights and FSM encoding for the 3x3 Gaussian filter.
package gauss_pkg;

    localparam int PIX_W_DEF  = 12;
    localparam int ADDR_W_DEF = 18;
    localparam int CH_W       = 4;
    localparam int ACC_W      = 8;
    localparam int WT_W       = 5;

    // Edge pixels pass through the same accumulator with weight 16, so sum/16 equals the input.
    localparam logic [WT_W-1:0] W_CORNER = 5'd1;
    localparam logic [WT_W-1:0] W_SIDE   = 5'd2;
    localparam logic [WT_W-1:0] W_CENTRE = 5'd4;
    localparam logic [WT_W-1:0] W_EDGE   = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    // Weight of a kernel tap numbered 0..8 in row-major order.
    function automatic logic [WT_W-1:0] tap_weight(input logic [3:0] tap);
        case (tap)
            4'd4:                    return W_CENTRE;
            4'd1, 4'd3, 4'd5, 4'd7:  return W_SIDE;
            default:                 return W_CORNER;
        endcase
    endfunction

endpackage

// File: rtl/gauss_filter_if.sv
// Frame-buffer read port, filtered-pixel write port and start/busy/done control.
interface gauss_filter_if #(
    parameter int ADDR_W = gauss_pkg::ADDR_W_DEF,
    parameter int PIX_W  = gauss_pkg::PIX_W_DEF
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] RdAddr;
    logic [PIX_W-1:0]  RdData;
    logic [PIX_W-1:0]  GaussDin;
    logic              GaussWea;
    logic [ADDR_W-1:0] GaussAddr;

    modport master (
        input  start, RdData,
        output busy, done, RdAddr, GaussDin, GaussWea, GaussAddr
    );

    modport slave (
        output start, RdData,
        input  busy, done, RdAddr, GaussDin, GaussWea, GaussAddr
    );
endinterface

// File: rtl/gauss_acc.sv
// One colour channel: weighted sum of 4-bit samples into an 8-bit accumulator.
module gauss_acc
    import gauss_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [WT_W-1:0]   weight,
    input  logic [CH_W-1:0]   din,
    output logic [ACC_W-1:0]  sum
);

    logic [ACC_W-1:0] prod;

    assign prod = ACC_W'(weight) * ACC_W'(din);

    // NOTE: state registers use <= so every accumulator and the FSM see the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  sum <= '0;
        else if (clr) sum <= '0;
        else if (en)  sum <= sum + prod;
    end

endmodule

// File: rtl/gauss_filter.sv
// Raster-order 3x3 Gaussian filter: 9 reads per interior pixel, centre copy on the border.
module gauss_filter
    import gauss_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PIX_W  = PIX_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    gauss_filter_if.master bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] UP_LEFT  = ADDR_W'(IMG_W + 1);

    state_t            state;
    logic [XW-1:0]     x, x_nxt;
    logic [YW-1:0]     y, y_nxt;
    logic [ADDR_W-1:0] cen, cen_nxt;
    logic [ADDR_W-1:0] rd_addr, gauss_addr;
    logic [3:0]        tap;
    logic [1:0]        col;
    logic              inner, inner_nxt, last_pix, fetch_last;
    logic              busy, done, wea;
    logic              acc_clr, acc_en;
    logic [WT_W-1:0]   wt;
    logic [ACC_W-1:0]  ch_sum [3];

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        last_pix = (x == X_LAST) && (y == Y_LAST);
        x_nxt    = x + 1'b1;
        y_nxt    = y;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = y + 1'b1;
        end
        cen_nxt   = cen + 1'b1;
        inner_nxt = (x_nxt != '0) && (x_nxt != X_LAST) && (y_nxt != '0) && (y_nxt != Y_LAST);
    end

    // Data returning in a cycle belongs to the tap issued one cycle earlier.
    always_comb begin
        fetch_last = inner ? (tap == 4'd8) : 1'b1;
        acc_clr    = (state == S_IDLE && bus.start) || (state == S_WRITE && !last_pix);
        acc_en     = (state == S_FETCH && tap != 4'd0) || (state == S_DRAIN);
        wt         = W_EDGE;
        if (inner) wt = (state == S_DRAIN) ? tap_weight(tap) : tap_weight(tap - 4'd1);
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        gauss_acc u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (acc_clr),
            .en     (acc_en),
            .weight (wt),
            .din    (bus.RdData[c*CH_W +: CH_W]),
            .sum    (ch_sum[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            cen        <= '0;
            rd_addr    <= '0;
            gauss_addr <= '0;
            tap        <= '0;
            col        <= '0;
            inner      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wea        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state   <= S_FETCH;
                    busy    <= 1'b1;
                    x       <= '0;
                    y       <= '0;
                    cen     <= '0;
                    rd_addr <= '0;
                    inner   <= 1'b0;
                    tap     <= '0;
                    col     <= '0;
                end
                S_FETCH: if (fetch_last) begin
                    state <= S_DRAIN;
                end else begin
                    tap <= tap + 1'b1;
                    if (col == 2'd2) begin
                        col     <= '0;
                        rd_addr <= rd_addr + ROW_STEP;
                    end else begin
                        col     <= col + 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state      <= S_WRITE;
                    wea        <= 1'b1;
                    gauss_addr <= cen;
                end
                S_WRITE: begin
                    wea <= 1'b0;
                    if (last_pix) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= S_FETCH;
                        x       <= x_nxt;
                        y       <= y_nxt;
                        cen     <= cen_nxt;
                        inner   <= inner_nxt;
                        tap     <= '0;
                        col     <= '0;
                        rd_addr <= inner_nxt ? cen_nxt - UP_LEFT : cen_nxt;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.RdAddr    = rd_addr;
    assign bus.GaussWea  = wea;
    assign bus.GaussAddr = gauss_addr;
    assign bus.GaussDin  = PIX_W'({CH_W'(ch_sum[2] >> CH_W),
                                   CH_W'(ch_sum[1] >> CH_W),
                                   CH_W'(ch_sum[0] >> CH_W)});

endmodule

// File: tb/tb_gauss_filter.sv
// Randomised frames on an 8x6 image checked against a convolution model of the Gaussian filter.
module tb_gauss_filter;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 18;
    localparam int PW = 12;
    localparam int FRAME_CYCLES = 24 * 11 + 24 * 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gauss_filter_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

    gauss_filter #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [11:0] img     [N];
    logic [11:0] exp_img [N];
    logic [11:0] out_img [N];
    bit          written [N];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int start_cyc, done_cyc, wr_count, done_count;
    bit active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: direct 3x3 convolution per channel, weight = (2-|dx|)*(2-|dy|), then /16.
    function automatic void build_model();
        for (int p = 0; p < N; p++) begin
            int px = p % W;
            int py = p / W;
            if (px >= 1 && px <= W - 2 && py >= 1 && py <= H - 2) begin
                logic [11:0] v = '0;
                for (int c = 0; c < 3; c++) begin
                    int s = 0;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            int wgt = (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy));
                            logic [11:0] nb = img[(py + dy) * W + px + dx];
                            s += wgt * int'(nb[c*4 +: 4]);
                        end
                    v[c*4 +: 4] = 4'(s / 16);
                end
                exp_img[p] = v;
            end else begin
                exp_img[p] = img[p];
            end
        end
    endfunction

    // Synchronous frame-buffer: data follows the address by one cycle.
    always @(posedge clk) bus.RdData <= (bus.RdAddr < AW'(N)) ? img[bus.RdAddr[5:0]] : '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int a;
        if (rst_n) begin
            if (!active) begin
                check("idle_wea", bus.GaussWea, 0);
            end else begin
                check("busy", bus.busy, (done_count == 0 && !bus.done));
                if (bus.GaussWea) begin
                    a = int'(bus.GaussAddr);
                    if (a < N) begin
                        check("addr_once", written[a], 0);
                        written[a] = 1'b1;
                        out_img[a] = bus.GaussDin;
                        check($sformatf("pix_%0d", a), bus.GaussDin, exp_img[a]);
                    end else begin
                        check("addr_range", a, N - 1);
                    end
                    wr_count++;
                end
                if (bus.done) begin
                    done_count++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic run_frame(input int extra_start_at, input int abort_at);
        bit aborted = 1'b0;
        for (int i = 0; i < N; i++) begin
            written[i] = 1'b0;
            out_img[i] = 12'hEEE;
        end
        wr_count   = 0;
        done_count = 0;
        done_cyc   = 0;
        build_model();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        active    = 1'b1;
        for (int i = 0; i < 2000 && done_count == 0 && !aborted; i++) begin
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                active  = 1'b0;
                rst_n   = 1'b0;
                aborted = 1'b1;
                #1;
                check("abort_wea",  bus.GaussWea,  0);
                check("abort_busy", bus.busy,      0);
                check("abort_done", bus.done,      0);
                check("abort_rd",   bus.RdAddr,    0);
                check("abort_addr", bus.GaussAddr, 0);
                check("abort_din",  bus.GaussDin,  0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (5) @(negedge clk);
            end else begin
                bus.start = (i == extra_start_at);
            end
        end
        if (!aborted) begin
            repeat (6) @(negedge clk);
            check("done_count", done_count, 1);
            check("writes",     wr_count,   N);
            check("latency",    done_cyc - start_cyc, FRAME_CYCLES);
            check("busy_end",   bus.busy,   0);
            active = 1'b0;
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.RdData = '0;
        rst_n      = 1'b1;
        for (int i = 0; i < N; i++) img[i] = '0;
        #2 rst_n = 1'b0;

        // Reset holds every output at zero even with start toggling.
        repeat (3) begin
            @(negedge clk);
            bus.start = ~bus.start;
        end
        @(negedge clk);
        check("rst_busy", bus.busy,      0);
        check("rst_done", bus.done,      0);
        check("rst_wea",  bus.GaussWea,  0);
        check("rst_din",  bus.GaussDin,  0);
        check("rst_addr", bus.GaussAddr, 0);
        check("rst_rd",   bus.RdAddr,    0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", bus.busy, 0);

        // Uniform frame.
        for (int i = 0; i < N; i++) img[i] = 12'hABC;
        build_model();
        check("model_uniform", exp_img[20], 12'hABC);
        run_frame(-1, -1);
        check("uniform_20", out_img[20], 12'hABC);

        // Impulse at (3,2).
        for (int i = 0; i < N; i++) img[i] = '0;
        img[19] = 12'hFFF;
        build_model();
        check("model_impulse", exp_img[19], 12'h333);
        run_frame(-1, -1);
        check("imp_19", out_img[19], 12'h333);
        check("imp_18", out_img[18], 12'h111);
        check("imp_20", out_img[20], 12'h111);
        check("imp_11", out_img[11], 12'h111);
        check("imp_27", out_img[27], 12'h111);
        check("imp_10", out_img[10], 12'h000);
        check("imp_12", out_img[12], 12'h000);
        check("imp_26", out_img[26], 12'h000);
        check("imp_28", out_img[28], 12'h000);

        // Border copy on a random frame.
        for (int i = 0; i < N; i++) img[i] = 12'($urandom_range(0, 4095));
        img[0]  = 12'h5A3;
        img[47] = 12'h1F0;
        run_frame(-1, -1);
        check("edge_0",  out_img[0],  12'h5A3);
        check("edge_47", out_img[47], 12'h1F0);

        // Stray start while busy.
        for (int i = 0; i < N; i++) img[i] = 12'($urandom_range(0, 4095));
        run_frame(48, -1);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < N; i++) img[i] = 12'($urandom_range(0, 4095));
        run_frame(-1, 98);
        check("post_abort_busy", bus.busy, 0);
        for (int i = 0; i < N; i++) img[i] = 12'($urandom_range(0, 4095));
        run_frame(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
